instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter BUFFER_DEPTH, default 2, prefetch buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_enable  input  1  permits new fetches when high.
REQ-006 imem_address  output  32  byte address driven to the combinational instruction memory.
REQ-007 imem_instruction  input  32  word returned by the instruction memory in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and restart fetch.
REQ-009 redirect_pc  input  32  new fetch byte address, sampled when redirect_valid is high.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr_ready  input  1  consumer accepts the head this cycle.
REQ-012 instr_out  output  32  instruction at buffer head.
REQ-013 instr_pc  output  32  byte address of instr_out.
REQ-014 fetch_error  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-015 imem_address SHALL equal fetch_pc, the internal fetch pointer, combinationally.
REQ-016 A push SHALL occur when fetch_enable is high, redirect_valid is low, fetch_error is low, and the buffer is not full or a pop occurs in the same cycle.
REQ-017 A push SHALL store {imem_instruction, fetch_pc} at the tail and advance fetch_pc by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-018 A pop SHALL occur when instr_valid and instr_ready are both high; it removes the head.
REQ-019 instr_valid SHALL be high exactly when the buffer count is nonzero; instr_out and instr_pc SHALL show the head entry with no added latency.
REQ-020 Fetch-to-output latency SHALL be one cycle: a word pushed in cycle N is visible at the head in cycle N+1 when the buffer was empty.
REQ-021 Simultaneous push and pop on a full buffer SHALL leave the count unchanged and drop no entry.
REQ-022 While the buffer is full and no pop occurs, fetch_pc SHALL hold and no push SHALL occur.
REQ-023 redirect_valid SHALL take priority over push and pop: all entries are discarded, count becomes 0, and fetch_pc loads redirect_pc on the next edge.
REQ-024 In the cycle after a redirect, instr_valid SHALL be low; the first redirected instruction SHALL appear one cycle later.
REQ-025 A pop in the same cycle as redirect_valid SHALL have no effect beyond the flush.
REQ-026 With fetch_enable low, no pushes SHALL occur, fetch_pc SHALL hold, and buffered entries SHALL remain poppable.

Reset
REQ-027 When reset is high at a rising edge: fetch_pc = RESET_PC, count = 0, read/write pointers = 0, fetch_error = 0.
REQ-028 While reset is high, instr_valid SHALL be 0; instr_out and instr_pc SHALL be 32'h0.
REQ-029 Reset SHALL override redirect_valid, push and pop in the same cycle, including when asserted mid-stream with a full buffer.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN SHALL gate misaligned-redirect detection.
REQ-031 With FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0] != 0 SHALL flush, load fetch_pc, and set fetch_error.
REQ-032 fetch_error SHALL stay set, blocking pushes, until reset or a redirect with redirect_pc[1:0] == 0 clears it.
REQ-033 With FETCH_MISALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0 on load, and fetch_error SHALL be tied to 0.

Verification
REQ-034 Reset, RESET_PC=0, fetch_enable=1, instr_ready=1, memory word k = k -> cycle 1 shows instr_out=0, instr_pc=0; each later cycle shows instr_pc +4 with instr_out +1.
REQ-035 instr_ready=0 for 5 cycles -> after 2 cycles count=2, imem_address holds at 0x8, the head stays pc 0x0; instr_ready=1 -> pc 0x0, 0x4, 0x8 pop on consecutive cycles with no gap.
REQ-036 Redirect to 0x40 with 2 entries buffered and instr_ready=1 -> next cycle instr_valid=0; the following cycle instr_pc=0x40; no pre-redirect entry is ever output.
REQ-037 Redirect to 0xFFFF_FFFC -> instr_pc sequence 0xFFFF_FFFC then 0x0000_0000.
REQ-038 FETCH_MISALIGN_CHECK_EN defined, redirect to 0x42 -> fetch_error=1 and instr_valid stays 0; redirect to 0x44 -> fetch_error=0 and instr_pc=0x44 two cycles later. Undefined: redirect to 0x42 -> instr_pc=0x40 and fetch_error=0.
REQ-039 reset asserted for one cycle with a full buffer and a redirect pending -> next cycle instr_valid=0, imem_address=RESET_PC, fetch_error=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch pointer plus a small prefetch FIFO in front of a
// combinational instruction memory. Redirects flush the FIFO and restart
// fetch at the new address.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag redirects to a
// non-word-aligned address (fetch_error) instead of silently aligning them.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_error
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  fetch_entry_t    buf_q [BUFFER_DEPTH];
  fetch_entry_t    head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             fetch_error_q, fetch_error_d;

  logic             buf_empty;
  logic             buf_full;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  redirect_target;
  logic             redirect_misaligned;

  // Redirect target: either kept as-is and flagged, or forced word-aligned.
`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    redirect_target     = redirect_pc;
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  end
`else
  always_comb begin
    redirect_target     = redirect_pc & 32'hFFFF_FFFC;
    redirect_misaligned = 1'b0;
  end
`endif

  // FIFO occupancy and handshake decode; reset and redirect suppress both moves.
  always_comb begin
    buf_empty = (count_q == '0);
    buf_full  = (count_q == CNT_W'(BUFFER_DEPTH));
    pop       = !reset && !redirect_valid && !buf_empty && instr_ready;
    push      = !reset && !redirect_valid && fetch_enable && !fetch_error_q &&
                (!buf_full || pop);
  end

  // Next-state for pointers, occupancy, fetch pointer and error flag.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_error_d = fetch_error_q;

    if (redirect_valid) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      fetch_pc_d    = redirect_target;
      fetch_error_d = redirect_misaligned;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      fetch_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // FIFO storage: capture the memory word and its address at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= '{instr: imem_instruction, pc: fetch_pc_q};
    end
  end

  // Head entry and externally visible signals; held quiet while in reset.
  always_comb begin
    head         = buf_q[rd_ptr_q];
    imem_address = fetch_pc_q;
    instr_valid  = !reset && !buf_empty;
    instr_out    = reset ? '0 : head.instr;
    instr_pc     = reset ? '0 : head.pc;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_error = fetch_error_q;
`else
  assign fetch_error = 1'b0;
`endif

  // Occupancy can never exceed the FIFO depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(BUFFER_DEPTH))
        else $error("instruction_fetch: occupancy overflow");
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized run checked against a queue-based reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit          CHK_EN   = 1'b1;
`else
  localparam bit          CHK_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_error;
  logic [31:0] salt = 32'h0;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  always #5 clk = ~clk;

  // Memory: word k holds k (xor salt for the random run).
  assign imem_instruction = {2'b00, imem_address[31:2]} ^ salt;

  instruction_fetch #(
    .RESET_PC    (RESET_PC),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_enable    (fetch_enable),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .fetch_error     (fetch_error)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ salt;
  endfunction

  // Reset over one edge; returns at the negedge of the first post-reset cycle.
  task automatic apply_reset(input logic en, input logic rdy);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    fetch_enable = en; instr_ready = rdy;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; fetch_enable = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b out=%h pc=%h expected v=0 out=0 pc=0", instr_valid, instr_out, instr_pc);
    end
    @(negedge clk); #1;
    tests_run++;
    if (imem_address !== RESET_PC || fetch_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got addr=%h err=%b expected addr=%h err=0", imem_address, fetch_error, RESET_PC);
    end
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_address !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_release: got v=%b addr=%h expected v=0 addr=%h", instr_valid, imem_address, RESET_PC);
    end
  endtask

  task automatic test_stream();
    salt = 32'h0;
    apply_reset(1'b1, 1'b1);
    #1;
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_first_cycle: got v=%b expected v=0", instr_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr_out !== 32'(k)) begin
        tests_failed++;
        $display("FAIL stream_k%0d: got v=%b pc=%h out=%h expected v=1 pc=%h out=%h",
                 k, instr_valid, instr_pc, instr_out, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (i >= 2) begin
        tests_run++;
        if (imem_address !== 32'h8 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL backpressure_hold_%0d: got addr=%h v=%b pc=%h expected addr=8 v=1 pc=0",
                   i, imem_address, instr_valid, instr_pc);
        end
      end
    end
    @(negedge clk);
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j)) begin
        tests_failed++;
        $display("FAIL backpressure_drain_%0d: got v=%b pc=%h expected v=1 pc=%h",
                 j, instr_valid, instr_pc, 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_address !== 32'h40) begin
      tests_failed++;
      $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=40", instr_valid, imem_address);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(32'h40 + 4 * j) || instr_out !== 32'(32'h10 + j)) begin
        tests_failed++;
        $display("FAIL redirect_seq_%0d: got v=%b pc=%h out=%h expected v=1 pc=%h out=%h",
                 j, instr_valid, instr_pc, instr_out, 32'(32'h40 + 4 * j), 32'(32'h10 + j));
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_out !== 32'h3FFF_FFFF) begin
      tests_failed++;
      $display("FAIL wrap_top: got v=%b pc=%h out=%h expected v=1 pc=fffffffc out=3fffffff", instr_valid, instr_pc, instr_out);
    end
    @(negedge clk); #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_zero: got v=%b pc=%h out=%h expected v=1 pc=0 out=0", instr_valid, instr_pc, instr_out);
    end
  endtask

  task automatic test_misalign();
    apply_reset(1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests_run++;
      if (fetch_error !== 1'b1 || instr_valid !== 1'b0 || imem_address !== 32'h42) begin
        tests_failed++;
        $display("FAIL misalign_set_%0d: got err=%b v=%b addr=%h expected err=1 v=0 addr=42",
                 i, fetch_error, instr_valid, imem_address);
      end
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h44;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (fetch_error !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_clear: got err=%b v=%b expected err=0 v=0", fetch_error, instr_valid);
    end
    @(negedge clk); #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h44) begin
      tests_failed++;
      $display("FAIL misalign_resume: got v=%b pc=%h expected v=1 pc=44", instr_valid, instr_pc);
    end
`else
    #1;
    tests_run++;
    if (fetch_error !== 1'b0 || imem_address !== 32'h40) begin
      tests_failed++;
      $display("FAIL misalign_align: got err=%b addr=%h expected err=0 addr=40", fetch_error, imem_address);
    end
    @(negedge clk); #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || fetch_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_resume: got v=%b pc=%h err=%b expected v=1 pc=40 err=0", instr_valid, instr_pc, fetch_error);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h83;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got v=%b pc=%h out=%h expected v=0 pc=0 out=0", instr_valid, instr_pc, instr_out);
    end
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_address !== RESET_PC || fetch_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: got v=%b addr=%h err=%b expected v=0 addr=%h err=0",
               instr_valid, imem_address, fetch_error, RESET_PC);
    end
    @(negedge clk); #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, RESET_PC);
    end
  endtask

  // Random traffic against a queue model built from the fetch rules.
  task automatic test_random();
    ent_t        q[$];
    logic [31:0] fpc;
    logic        err;
    logic        exp_valid;
    logic        do_pop;
    logic        do_push;
    salt = $urandom;
    apply_reset(1'b1, 1'b1);
    fpc = RESET_PC;
    err = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      reset          = ($urandom_range(0, 199) == 0);
      fetch_enable   = ($urandom_range(0, 7) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 9) < 7) redirect_pc[1:0] = 2'b00;
      #1;
      exp_valid = !reset && (q.size() != 0);
      tests_run++;
      if (instr_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_valid c%0d: got %b expected %b", c, instr_valid, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (instr_pc !== q[0].pc || instr_out !== q[0].instr) begin
          tests_failed++;
          $display("FAIL rand_head c%0d: got pc=%h out=%h expected pc=%h out=%h",
                   c, instr_pc, instr_out, q[0].pc, q[0].instr);
        end
      end
      tests_run++;
      if (imem_address !== fpc || fetch_error !== err) begin
        tests_failed++;
        $display("FAIL rand_fetch c%0d: got addr=%h err=%b expected addr=%h err=%b",
                 c, imem_address, fetch_error, fpc, err);
      end
      if (reset) begin
        q.delete();
        fpc = RESET_PC;
        err = 1'b0;
      end else if (redirect_valid) begin
        q.delete();
        if (CHK_EN) begin
          fpc = redirect_pc;
          err = (redirect_pc[1:0] != 2'b00);
        end else begin
          fpc = {redirect_pc[31:2], 2'b00};
        end
      end else begin
        do_pop  = (q.size() != 0) && instr_ready;
        do_push = fetch_enable && !err && ((q.size() < DEPTH) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back('{instr: mem_word(fpc), pc: fpc});
          fpc = fpc + 32'd4;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
